// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer, mid-bit sampling and a
// single-entry valid/ack output register. Framing errors and overruns are one-cycle pulses.
module uart_rx #(
    parameter int unsigned DIVIDER = 25000000 / 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CntW = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(DIVIDER / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(DIVIDER - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            deliver;
    logic            s_sync;

    assign s_sync = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], serial};
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        if (valid_q && ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!s_sync) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Half a bit in: confirm the start bit, then sample every full bit period.
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (s_sync) begin
                        state_d = StIdle;
                    end else begin
                        state_d  = StData;
                        bitcnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d    = '0;
                    shift_d  = {s_sync, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (s_sync) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                // Hold off until the line is released so a stuck-low line cannot retrigger.
                cnt_d = '0;
                if (s_sync) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (deliver) begin
            if (!valid_q || ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed vector table, corner-case sequences and a randomized loopback
// against a timing/ordering model derived from the frame arithmetic.
module tb_uart_rx;

    localparam int unsigned DIV = 16;
    localparam int TSTOP = 2 + DIV / 2 + 9 * DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.DIVIDER(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .serial   (serial),
        .data     (data),
        .valid    (valid),
        .ack      (ack),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         hold;
        logic       glitch;
        logic       exp_valid;
        logic       exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs [4];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         ack_at = -1;
    bit         auto_ack = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ack = 1'b0;
    int         both_cnt = 0;
    int         dlv_cyc [$];
    logic [7:0] dlv_data [$];
    int         fe_cyc [$];
    int         ov_cyc [$];
    int         exp_c [$];
    logic [7:0] exp_q [$];
    int         e0;
    int         p;
    int         gap;
    logic [7:0] rb;
    logic [9:0] fr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ack = (auto_ack && valid) || (ack_at >= 0 && cyc + 1 == ack_at);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
    endtask

    task automatic clear_log();
        dlv_cyc.delete();
        dlv_data.delete();
        fe_cyc.delete();
        ov_cyc.delete();
    endtask

    // p is the bit period in hundredths of a clock cycle, to model a slightly off-rate sender.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per);
        logic [9:0] f;
        int n;
        f = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            serial = f[k];
            n = ((k + 1) * per) / 100 - (k * per) / 100;
            repeat (n) tick();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Event log: a delivery is a cycle where valid is high and was free (idle or just acked).
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (valid === 1'b1 && (!prev_valid || prev_ack)) begin
                dlv_cyc.push_back(cyc);
                dlv_data.push_back(data);
            end
            if (frame_err === 1'b1) fe_cyc.push_back(cyc);
            if (overrun === 1'b1) ov_cyc.push_back(cyc);
            if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
            prev_valid = valid;
            prev_ack   = ack;
        end
    end

    initial begin
        vecs[0] = '{b: 8'hA5, stop: 1'b1, hold: 0, glitch: 1'b0,
                    exp_valid: 1'b1, exp_fe: 1'b0, exp_data: 8'hA5};
        vecs[1] = '{b: 8'h3C, stop: 1'b1, hold: 0, glitch: 1'b1,
                    exp_valid: 1'b1, exp_fe: 1'b0, exp_data: 8'h3C};
        vecs[2] = '{b: 8'h00, stop: 1'b0, hold: 40, glitch: 1'b0,
                    exp_valid: 1'b0, exp_fe: 1'b1, exp_data: 8'h3C};
        vecs[3] = '{b: 8'hFF, stop: 1'b1, hold: 0, glitch: 1'b0,
                    exp_valid: 1'b1, exp_fe: 1'b0, exp_data: 8'hFF};

        reset  = 1'b1;
        serial = 1'b1;
        ack    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        check("reset_data", 32'(data), 0);
        check("reset_valid", 32'(valid), 0);
        check("reset_frame_err", 32'(frame_err), 0);
        check("reset_overrun", 32'(overrun), 0);

        for (int i = 0; i < 4; i++) begin
            clear_log();
            if (vecs[i].glitch) begin
                serial = 1'b0;
                repeat (3) tick();
                serial = 1'b1;
                repeat (24) tick();
                check("glitch_valid", 32'(valid), 0);
                check("glitch_events", dlv_cyc.size() + fe_cyc.size() + ov_cyc.size(), 0);
            end
            e0 = cyc + 1;
            ack_at = vecs[i].exp_valid ? e0 + TSTOP + 1 : -1;
            send_frame(vecs[i].b, vecs[i].stop, 100 * DIV);
            if (vecs[i].hold > 0) begin
                repeat (vecs[i].hold) tick();
                check("break_held_fe", fe_cyc.size(), 1);
                check("break_held_dlv", dlv_cyc.size(), 0);
            end
            serial = 1'b1;
            repeat ((vecs[i].hold > 0) ? 200 : 8) tick();
            ack_at = -1;
            check("vec_dlv_count", dlv_cyc.size(), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid && dlv_cyc.size() > 0) begin
                check("vec_dlv_cycle", dlv_cyc[0], e0 + TSTOP);
                check("vec_dlv_data", 32'(dlv_data[0]), 32'(vecs[i].exp_data));
            end
            check("vec_fe_count", fe_cyc.size(), 32'(vecs[i].exp_fe));
            if (vecs[i].exp_fe && fe_cyc.size() > 0) begin
                check("vec_fe_cycle", fe_cyc[0], e0 + TSTOP);
            end
            check("vec_overrun", ov_cyc.size(), 0);
            check("vec_data", 32'(data), 32'(vecs[i].exp_data));
            check("vec_valid_after_ack", 32'(valid), 0);
        end

        // Overrun: second byte arrives while the first is still unacknowledged.
        clear_log();
        e0 = cyc + 1;
        send_frame(8'h11, 1'b1, 100 * DIV);
        send_frame(8'h22, 1'b1, 100 * DIV);
        repeat (8) tick();
        check("ovr_dlv_count", dlv_cyc.size(), 1);
        check("ovr_count", ov_cyc.size(), 1);
        if (ov_cyc.size() > 0) check("ovr_cycle", ov_cyc[0], e0 + 10 * DIV + TSTOP);
        check("ovr_data_kept", 32'(data), 32'h11);
        check("ovr_valid_kept", 32'(valid), 1);
        check("ovr_no_fe", fe_cyc.size(), 0);
        do_ack();
        check("ovr_acked", 32'(valid), 0);

        // Ack lands exactly on the second stop sample: replace, no overrun.
        clear_log();
        e0 = cyc + 1;
        ack_at = e0 + 10 * DIV + TSTOP;
        send_frame(8'h11, 1'b1, 100 * DIV);
        send_frame(8'h22, 1'b1, 100 * DIV);
        repeat (8) tick();
        ack_at = -1;
        check("swap_dlv_count", dlv_cyc.size(), 2);
        if (dlv_cyc.size() == 2) begin
            check("swap_second_cycle", dlv_cyc[1], e0 + 10 * DIV + TSTOP);
            check("swap_second_data", 32'(dlv_data[1]), 32'h22);
        end
        check("swap_overrun", ov_cyc.size(), 0);
        check("swap_data", 32'(data), 32'h22);
        check("swap_valid", 32'(valid), 1);

        // Reset during data bit 4 with a byte still pending.
        clear_log();
        fr = {1'b1, 8'hC3, 1'b0};
        for (int k = 0; k < 10; k++) begin
            serial = fr[k];
            if (k == 5) begin
                repeat (8) tick();
                reset = 1'b1;
                tick();
                check("midrst_data", 32'(data), 0);
                check("midrst_valid", 32'(valid), 0);
                check("midrst_frame_err", 32'(frame_err), 0);
                check("midrst_overrun", 32'(overrun), 0);
                repeat (DIV - 9) tick();
            end else begin
                repeat (DIV) tick();
            end
        end
        reset = 1'b0;
        repeat (20) tick();
        check("midrst_dropped", dlv_cyc.size() + fe_cyc.size() + ov_cyc.size(), 0);
        clear_log();
        e0 = cyc + 1;
        ack_at = e0 + TSTOP + 1;
        send_frame(8'h5A, 1'b1, 100 * DIV);
        repeat (8) tick();
        ack_at = -1;
        check("post_rst_count", dlv_cyc.size(), 1);
        if (dlv_cyc.size() > 0) begin
            check("post_rst_cycle", dlv_cyc[0], e0 + TSTOP);
            check("post_rst_data", 32'(dlv_data[0]), 32'h5A);
        end

        // Loopback: all byte values back-to-back, then random bytes, gaps and +/-2% rates.
        auto_ack = 1'b1;
        clear_log();
        for (int b = 0; b < 256; b++) begin
            exp_q.push_back(8'(b));
            exp_c.push_back(cyc + 1 + TSTOP);
            send_frame(8'(b), 1'b1, 100 * DIV);
        end
        repeat (40) begin
            gap = $urandom_range(0, 12);
            repeat (gap) tick();
            p  = 98 * DIV + 2 * DIV * $urandom_range(0, 2);
            rb = 8'($urandom);
            exp_q.push_back(rb);
            exp_c.push_back(cyc + 1 + TSTOP);
            send_frame(rb, 1'b1, p);
        end
        repeat (200) tick();
        auto_ack = 1'b0;
        check("lb_count", dlv_data.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < dlv_data.size(); k++) begin
            check("lb_data", 32'(dlv_data[k]), 32'(exp_q[k]));
            check("lb_cycle", dlv_cyc[k], exp_c[k]);
        end
        check("lb_frame_err", fe_cyc.size(), 0);
        check("lb_overrun", ov_cyc.size(), 0);
        check("err_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
